// File: rtl/wheel_turn_scheduler.sv
// Wheel turn scheduler: round-robin turn arbitration, spin sequencing for one
// external 4-bit score counter, per-player score totals and winner selection.

module wheel_player_slot #(
    parameter int ROUNDS  = 3,
    parameter int TOTAL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               upd,
    input  logic [3:0]         score,
    output logic [TOTAL_W-1:0] total,
    output logic               finished
);
    logic [3:0]       turns;
    logic [TOTAL_W:0] sum;

    // One extra bit catches the carry so the total saturates instead of wrapping.
    assign sum      = {1'b0, total} + (TOTAL_W+1)'(score);
    assign finished = (turns == 4'(ROUNDS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total <= '0;
            turns <= '0;
        end else if (clr) begin
            total <= '0;
            turns <= '0;
        end else if (upd) begin
            total <= sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
            turns <= turns + 4'd1;
        end
    end
endmodule

module wheel_turn_scheduler #(
    parameter int         PLAYERS     = 2,
    parameter int         ROUNDS      = 3,
    parameter int         SPIN_CYCLES = 8,
    parameter logic [7:0] SEED        = 8'h01,
    parameter int         TOTAL_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [PLAYERS-1:0] req,
    output logic [PLAYERS-1:0] grant,
    output logic               cnt_reset,
    output logic               cnt_enable,
    output logic               cnt_bit,
    input  logic [3:0]         cnt_score,
    output logic               busy,
    output logic               done,
    output logic [1:0]         winner,
    output logic [TOTAL_W-1:0] winner_score
);
    typedef enum logic [2:0] {IDLE, ARB, CLEAR, SPIN, SETTLE, DONE} state_t;

    state_t                          state, state_nxt;
    logic [7:0]                      lfsr, spin_cnt;
    logic [1:0]                      ptr, pick, best_idx;
    logic                            pick_vld, all_finished, new_game;
    logic [PLAYERS-1:0]              finished, eligible, rot;
    logic [PLAYERS-1:0][TOTAL_W-1:0] totals;
    logic [TOTAL_W-1:0]              best_val;
    logic [2:0]                      idx;

    assign eligible     = req & ~finished;
    assign all_finished = &finished;
    assign new_game     = start && !abort && (state == IDLE || state == DONE);

    for (genvar i = 0; i < PLAYERS; i++) begin : g_slot
        wheel_player_slot #(.ROUNDS(ROUNDS), .TOTAL_W(TOTAL_W)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .clr      (new_game),
            .upd      (state == SETTLE && grant[i] && !abort),
            .score    (cnt_score),
            .total    (totals[i]),
            .finished (finished[i])
        );
    end

    // rot[k] is the eligibility of player (ptr+k) mod PLAYERS; lowest k wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = '0;
        rot      = PLAYERS'({eligible, eligible} >> ptr);
        for (int k = PLAYERS-1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_vld = 1'b1;
                idx      = {1'b0, ptr} + 3'(k);
                if (idx >= 3'(PLAYERS)) idx = idx - 3'(PLAYERS);
                pick     = idx[1:0];
            end
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = totals[0];
        for (int i = 1; i < PLAYERS; i++) begin
            if (totals[i] > best_val) begin
                best_val = totals[i];
                best_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARB;
            ARB:     if (all_finished) state_nxt = DONE;
                     else if (pick_vld) state_nxt = CLEAR;
            CLEAR:   state_nxt = SPIN;
            SPIN:    if (spin_cnt == 8'(SPIN_CYCLES-1)) state_nxt = SETTLE;
            SETTLE:  state_nxt = ARB;
            DONE:    if (start) state_nxt = ARB;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            grant        <= '0;
            ptr          <= '0;
            lfsr         <= SEED;
            spin_cnt     <= '0;
            winner       <= '0;
            winner_score <= '0;
        end else begin
            state    <= state_nxt;
            spin_cnt <= (state == SPIN) ? spin_cnt + 8'd1 : '0;
            if (state == SPIN)
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (abort || state == SETTLE) begin
                grant <= '0;
            end else if (state == ARB && !all_finished && pick_vld) begin
                grant <= {{(PLAYERS-1){1'b0}}, 1'b1} << pick;
                ptr   <= (pick == 2'(PLAYERS-1)) ? 2'd0 : pick + 2'd1;
            end
            if (new_game) begin
                winner       <= '0;
                winner_score <= '0;
            end else if (state == ARB && all_finished && !abort) begin
                winner       <= best_idx;
                winner_score <= best_val;
            end
        end
    end

    assign busy       = state inside {ARB, CLEAR, SPIN, SETTLE};
    assign done       = (state == DONE);
    assign cnt_reset  = (state == CLEAR);
    assign cnt_enable = (state == SPIN);
    assign cnt_bit    = (state == SPIN) && lfsr[7];
endmodule

// File: tb/tb_wheel_turn_scheduler.sv
// Randomized scoreboard bench for wheel_turn_scheduler with a turn-level game
// model and a behavioural model of the external score counter.

module tb_wheel_turn_scheduler;
    localparam int         P    = 3;
    localparam int         R    = 2;
    localparam int         S    = 8;
    localparam int         TW   = 8;
    localparam logic [7:0] SEED = 8'h01;

    typedef struct {
        bit          is_result;
        int          player;
        int          nbits;
        logic [15:0] bits;
        int          val;
    } rec_t;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic [P-1:0]  req = '0, grant;
    logic          cnt_reset, cnt_enable, cnt_bit, busy, done;
    logic [3:0]    cnt_score;
    logic [1:0]    winner;
    logic [TW-1:0] winner_score;

    logic          start_s = 1'b0;
    logic [1:0]    req_s = 2'b11, grant_s, winner_s;
    logic          cnt_reset_s, cnt_enable_s, cnt_bit_s, busy_s, done_s;
    logic [3:0]    winner_score_s;

    int            checks = 0, failures = 0;
    rec_t          sbq[$];
    logic [7:0]    m_lfsr = SEED;
    int            m_ptr = 0;

    always #5 clk = ~clk;

    wheel_turn_scheduler #(.PLAYERS(P), .ROUNDS(R), .SPIN_CYCLES(S), .SEED(SEED), .TOTAL_W(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .req(req), .grant(grant),
        .cnt_reset(cnt_reset), .cnt_enable(cnt_enable), .cnt_bit(cnt_bit), .cnt_score(cnt_score),
        .busy(busy), .done(done), .winner(winner), .winner_score(winner_score)
    );

    // Saturation instance: its counter is a fixed score of 9.
    wheel_turn_scheduler #(.PLAYERS(2), .ROUNDS(3), .SPIN_CYCLES(2), .SEED(SEED), .TOTAL_W(4)) dut_sat (
        .clk(clk), .reset(reset), .start(start_s), .abort(1'b0), .req(req_s), .grant(grant_s),
        .cnt_reset(cnt_reset_s), .cnt_enable(cnt_enable_s), .cnt_bit(cnt_bit_s), .cnt_score(4'd9),
        .busy(busy_s), .done(done_s), .winner(winner_s), .winner_score(winner_score_s)
    );

    // External score counter: counts a point for every enabled 0 bit, wraps at 16.
    always @(posedge clk or negedge reset) begin
        if (!reset)                       cnt_score <= '0;
        else if (cnt_reset)               cnt_score <= '0;
        else if (cnt_enable && !cnt_bit)  cnt_score <= cnt_score + 4'd1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Plays a whole game at turn granularity and queues the expected turns/result.
    task automatic predict(input logic [P-1:0] mask, input int n_a, input int cut_turn, input int cut_k);
        int         tot[P];
        int         trn[P];
        int         t, pick, nb, zeros, w;
        bit         fin;
        logic [P-1:0] rq;
        rec_t       e;
        for (int i = 0; i < P; i++) begin tot[i] = 0; trn[i] = 0; end
        t = 0;
        forever begin
            fin = 1'b1;
            for (int i = 0; i < P; i++) if (trn[i] < R) fin = 1'b0;
            if (fin) begin
                w = 0;
                for (int i = 1; i < P; i++) if (tot[i] > tot[w]) w = i;
                e.is_result = 1'b1; e.player = w; e.nbits = 0; e.bits = '0; e.val = tot[w];
                sbq.push_back(e);
                return;
            end
            rq = (t < n_a) ? mask : '1;
            pick = -1;
            for (int k = 0; k < P; k++) begin
                w = (m_ptr + k) % P;
                if (pick < 0 && rq[w] && trn[w] < R) pick = w;
            end
            if (pick < 0) return;
            m_ptr = (pick + 1) % P;
            t++;
            nb = (t == cut_turn) ? cut_k : S;
            e.bits = '0;
            zeros = 0;
            for (int j = 0; j < nb; j++) begin
                e.bits[j] = m_lfsr[7];
                if (!m_lfsr[7]) zeros++;
                m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            end
            e.is_result = 1'b0; e.player = pick; e.nbits = nb; e.val = zeros % 16;
            sbq.push_back(e);
            if (t == cut_turn) return;
            tot[pick] = (tot[pick] + e.val > (1 << TW) - 1) ? (1 << TW) - 1 : tot[pick] + e.val;
            trn[pick]++;
        end
    endtask

    task automatic run_game(input logic [P-1:0] mask, input int cut_turn, input int cut_k,
                            input bit cut_rst, input bit idle_wait);
        int n_a, turn, spin, cyc, bad;
        n_a = $countones(mask) * R;
        predict(mask, n_a, cut_turn, cut_k);
        turn = 0; spin = 0; cyc = 0; bad = 0;
        req = idle_wait ? '0 : mask;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_clears", {done, winner_score}, 0);
        if (idle_wait) begin
            repeat (50) begin
                if (!busy || grant != '0 || cnt_enable) bad++;
                @(negedge clk);
            end
            check("arb_hold", bad, 0);
            req = mask;
            @(negedge clk);
            check("late_grant", grant, mask);
        end
        while (!done && cyc < 3000) begin
            if (cnt_reset) begin
                turn++;
                spin = 0;
                req = (turn >= n_a) ? '1 : mask;
            end
            if (cut_rst && turn == cut_turn && busy && !cnt_enable && !cnt_reset && spin == S) begin
                #1 reset = 1'b0;
                #1;
                check("rst_grant", grant, 0);
                check("rst_busy", busy, 0);
                check("rst_cnt_done", {cnt_reset, cnt_enable, cnt_bit, done}, 0);
                check("rst_winner", {winner, winner_score}, 0);
                m_lfsr = SEED;
                m_ptr = 0;
                @(negedge clk); @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (cnt_enable) begin
                spin++;
                if (!cut_rst && turn == cut_turn && spin == cut_k) begin
                    start = 1'b0;
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_grant", grant, 0);
                    check("abort_enable", cnt_enable, 0);
                    check("abort_busy", busy, 0);
                    return;
                end
                if (spin < S) begin
                    req = P'($urandom);
                    start = ($urandom_range(0, 5) == 0);
                end else begin
                    req = (turn >= n_a) ? '1 : mask;
                    start = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("game_done", done, 1);
        if (!idle_wait) check("game_latency", cyc, P * R * (S + 3) + 1);
    endtask

    // Monitor: collects each enable run and each DONE entry and compares.
    initial begin : monitor
        bit           prev_en, prev_done;
        int           nb;
        logic [15:0]  bits;
        logic [P-1:0] g;
        rec_t         e;
        prev_en = 1'b0; prev_done = 1'b0; nb = 0; bits = '0; g = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_en = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (cnt_enable) begin
                    if (!prev_en) begin nb = 0; bits = '0; g = grant; end
                    if (nb < 16) bits[4'(nb)] = cnt_bit;
                    nb++;
                end
                if ((prev_en && !cnt_enable) || (done && !prev_done)) begin
                    if (sbq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_unexpected got=output event expected=nothing queued");
                    end else begin
                        e = sbq.pop_front();
                        if (prev_en && !cnt_enable) begin
                            check("turn_kind", 32'(e.is_result), 0);
                            check("turn_player", g, 32'(1) << e.player);
                            check("turn_len", nb, e.nbits);
                            check("turn_bits", bits, e.bits);
                        end else begin
                            check("result_kind", 32'(e.is_result), 1);
                            check("winner", winner, e.player);
                            check("winner_score", winner_score, e.val);
                            check("done_idle", {busy, grant}, 0);
                        end
                    end
                end
                prev_en = cnt_enable;
                prev_done = done;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int exp_s, cyc;
        #1;
        check("reset_grant", grant, 0);
        check("reset_busy_done", {busy, done}, 0);
        check("reset_cnt", {cnt_reset, cnt_enable, cnt_bit}, 0);
        check("reset_result", {winner, winner_score}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_game('1, 0, 0, 1'b0, 1'b0);
        repeat (4) run_game(P'($urandom_range(1, (1 << P) - 1)), 0, 0, 1'b0, 1'b0);
        run_game('1, $urandom_range(1, P * R - 1), 4, 1'b0, 1'b0);
        run_game(3'b011, 0, 0, 1'b0, 1'b0);
        run_game(3'b010, 0, 0, 1'b0, 1'b1);
        run_game('1, 3, S, 1'b1, 1'b0);
        run_game('1, 0, 0, 1'b0, 1'b0);

        exp_s = 0;
        for (int r = 0; r < 3; r++) exp_s = (exp_s + 9 > 15) ? 15 : exp_s + 9;
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        cyc = 0;
        while (!done_s && cyc < 500) begin @(negedge clk); cyc++; end
        check("sat_done", done_s, 1);
        check("sat_winner", winner_s, 0);
        check("sat_score", winner_score_s, exp_s);

        repeat (3) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
